// File: rtl/uart_t_ram.sv
// uart_t_ram: 16-deep x 32-bit transmit buffer feeding an 8N1 UART serializer.
// Each buffered word goes out as four back-to-back frames, low byte first.
// Consecutive words are sent with no idle time between them.
module uart_t_ram #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clkout,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count,
    output logic        overflow,
    output logic        busy,
    output logic        word_done,
    output logic        tx
);

    // The bit-period counter must hold CLKS_PER_BIT-1 without wrapping.
    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [16];
    logic [3:0]    wr_ptr, rd_ptr;
    logic [4:0]    cnt;
    logic          ovf;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [31:0]   shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          push, pop, bit_end;

    assign full      = (cnt == 5'd16);
    assign empty     = (cnt == 5'd0);
    assign count     = cnt;
    assign overflow  = ovf;
    assign busy      = (state != IDLE);
    assign tx        = tx_q;
    // A write at full is dropped even when a pop frees a slot on the same edge.
    assign push      = wr_en && !full;
    assign bit_end   = (clk_cnt == LAST);
    assign word_done = (state == STOP) && bit_end && (byte_idx == 2'd3);

    // Buffer pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            cnt    <= 5'd0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 5'd1;
                2'b01:   cnt <= cnt - 5'd1;
                default: cnt <= cnt;
            endcase
            if (wr_en && full) ovf <= 1'b1;
        end
    end

    // Buffer storage; contents are don't-care until written.
    always_ff @(posedge clkout) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Serializer state and datapath registers.
    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 32'd0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
        end
    end

    // Next-state logic; tx is computed one cycle ahead so the line is registered.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        tx_n       = tx_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n      = 1'b1;
                clk_cnt_n = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_n    = mem[rd_ptr];
                    byte_idx_n = 2'd0;
                    bit_idx_n  = 3'd0;
                    tx_n       = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    // Shifting after every bit leaves the next byte in [7:0].
                    shreg_n   = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    if (byte_idx != 2'd3) begin
                        byte_idx_n = byte_idx + 2'd1;
                        tx_n       = 1'b0;
                        state_n    = START;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        shreg_n    = mem[rd_ptr];
                        byte_idx_n = 2'd0;
                        tx_n       = 1'b0;
                        state_n    = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
